// File: rtl/gf180mcu_osu_sc_12t_aoi_pipe_pkg.sv
// Shared width helpers for the pipelined AOI array and its toggle counters.
package gf180mcu_osu_sc_12t_aoi_pipe_pkg;

  function automatic int term_w(input int ch, input int g);
    return ch * g;
  endfunction

  function automatic int a_w(input int ch, input int g, input int w);
    return ch * g * w;
  endfunction

  // Bit position of input w of group g in channel c.
  function automatic int idx(input int c, input int g, input int w,
                             input int n_g, input int n_w);
    return (c * n_g + g) * n_w + w;
  endfunction

  function automatic longint unsigned cnt_max(input int cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_12t_aoi_pipe_if.sv
// Handshake, operand/result and counter bundle of the AOI pipe.
interface gf180mcu_osu_sc_12t_aoi_pipe_if
  import gf180mcu_osu_sc_12t_aoi_pipe_pkg::*;
#(
  parameter int CH    = 4,
  parameter int G     = 2,
  parameter int W     = 2,
  parameter int CNT_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [a_w(CH,G,W)-1:0] a;
  logic                   out_valid;
  logic                   out_ready;
  logic [CH-1:0]          y;
  logic                   cnt_clr;
  logic [CH*CNT_W-1:0]    tog_cnt;

  modport master (
    output in_valid, a, out_ready, cnt_clr,
    input  in_ready, out_valid, y, tog_cnt
  );

  modport slave (
    input  in_valid, a, out_ready, cnt_clr,
    output in_ready, out_valid, y, tog_cnt
  );
endinterface

// File: rtl/gf180mcu_osu_sc_12t_aoi_pipe_sat_cnt.sv
// Saturating up-counter; clear has priority over increment.
module gf180mcu_osu_sc_12t_aoi_pipe_sat_cnt
  import gf180mcu_osu_sc_12t_aoi_pipe_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);
  localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(cnt_max(CNT_W));

  always_ff @(posedge clk) begin
    if (!rn)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (inc && (q != MAX_Q))
      q <= q + CNT_W'(1);
  end
endmodule

// File: rtl/gf180mcu_osu_sc_12t_aoi_pipe.sv
// Two-stage registered AND-OR-INVERT array with valid/ready flow control
// and per-channel output toggle counters.
module gf180mcu_osu_sc_12t_aoi_pipe
  import gf180mcu_osu_sc_12t_aoi_pipe_pkg::*;
#(
  parameter int CH    = 4,
  parameter int G     = 2,
  parameter int W     = 2,
  parameter int CNT_W = 8
) (
  input logic                            clk,
  input logic                            rn,
  gf180mcu_osu_sc_12t_aoi_pipe_if.slave  bus
);
  localparam int TERM_W = term_w(CH, G);

  logic [TERM_W-1:0] terms_d;
  logic [TERM_W-1:0] terms_q;
  logic [CH-1:0]     y_d;
  logic [CH-1:0]     y_q;
  logic [CH-1:0]     tog_inc;
  logic              s1_valid;
  logic              out_valid;
  logic              s2_take;
  logic              s2_load;
  logic              in_ready;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar g = 0; g < G; g++) begin : g_grp
      assign terms_d[c*G+g] = &bus.a[idx(c, g, 0, G, W) +: W];
    end
    assign y_d[c]     = ~|terms_q[c*G +: G];
    assign tog_inc[c] = s2_load & (y_d[c] ^ y_q[c]);
  end

  // Stage 2 frees up whenever it is empty or being drained this cycle.
  assign s2_take  = ~out_valid | bus.out_ready;
  assign s2_load  = s1_valid & s2_take;
  assign in_ready = ~s1_valid | s2_take;

  always_ff @(posedge clk) begin
    if (!rn) begin
      s1_valid  <= 1'b0;
      terms_q   <= '0;
      out_valid <= 1'b0;
      y_q       <= '1;
    end else begin
      if (in_ready)
        s1_valid <= bus.in_valid;
      if (bus.in_valid && in_ready)
        terms_q <= terms_d;
      if (s2_take)
        out_valid <= s1_valid;
      if (s2_load)
        y_q <= y_d;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_cnt
    gf180mcu_osu_sc_12t_aoi_pipe_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rn  (rn),
      .clr (bus.cnt_clr),
      .inc (tog_inc[c]),
      .q   (bus.tog_cnt[c*CNT_W +: CNT_W])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y         = y_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_aoi_pipe.sv
// Bench: two instances (8-bit and 2-bit counters) driven in lockstep and
// compared against a queue-based reference model of the AOI pipe.
module tb_gf180mcu_osu_sc_12t_aoi_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rn_t   = 1'b0;
  logic        iv_t   = 1'b0;
  logic [15:0] a_t    = '0;
  logic        ordy_t = 1'b0;
  logic        clr_t  = 1'b0;

  gf180mcu_osu_sc_12t_aoi_pipe_if #(.CH(4), .G(2), .W(2), .CNT_W(8)) bus8 ();
  gf180mcu_osu_sc_12t_aoi_pipe_if #(.CH(4), .G(2), .W(2), .CNT_W(2)) bus2 ();

  assign bus8.in_valid  = iv_t;
  assign bus8.a         = a_t;
  assign bus8.out_ready = ordy_t;
  assign bus8.cnt_clr   = clr_t;
  assign bus2.in_valid  = iv_t;
  assign bus2.a         = a_t;
  assign bus2.out_ready = ordy_t;
  assign bus2.cnt_clr   = clr_t;

  gf180mcu_osu_sc_12t_aoi_pipe #(.CH(4), .G(2), .W(2), .CNT_W(8)) dut8 (
    .clk (clk), .rn (rn_t), .bus (bus8)
  );
  gf180mcu_osu_sc_12t_aoi_pipe #(.CH(4), .G(2), .W(2), .CNT_W(2)) dut2 (
    .clk (clk), .rn (rn_t), .bus (bus2)
  );

  typedef struct {
    logic [3:0] y;
    int         age;
    bit         shown;
  } item_t;

  item_t      q[$];
  logic [3:0] last_y = 4'hF;
  int         cnt8[4];
  int         cnt2[4];
  int         total = 0;
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  bit         checking = 0;

  // Channel c is low when any of its two 2-bit groups is all ones.
  function automatic logic [3:0] aoi(input logic [15:0] av);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) begin
      bit any = 0;
      for (int g = 0; g < 2; g++)
        if (((av >> ((c*2+g)*2)) & 16'd3) == 16'd3) any = 1;
      r[c] = !any;
    end
    return r;
  endfunction

  function automatic bit m_out_valid();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  function automatic bit m_in_ready();
    return (q.size() < 2) || ordy_t;
  endfunction

  task automatic model_edge();
    if (!rn_t) begin
      q.delete();
      last_y = 4'hF;
      for (int c = 0; c < 4; c++) begin cnt8[c] = 0; cnt2[c] = 0; end
    end else begin
      bit acc;
      bit ov;
      ov  = m_out_valid();
      acc = iv_t && m_in_ready();
      if (ov && ordy_t) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (acc) q.push_back('{y: aoi(a_t), age: 0, shown: 0});
      if (q.size() > 0 && q[0].age >= 1 && !q[0].shown) begin
        for (int c = 0; c < 4; c++)
          if (q[0].y[c] != last_y[c]) begin
            if (cnt8[c] < 255) cnt8[c]++;
            if (cnt2[c] < 3)   cnt2[c]++;
          end
        last_y = q[0].y;
        q[0].shown = 1;
      end
      if (clr_t)
        for (int c = 0; c < 4; c++) begin cnt8[c] = 0; cnt2[c] = 0; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] e8;
    logic [7:0]  e2;
    for (int c = 0; c < 4; c++) begin
      e8[c*8 +: 8] = 8'(cnt8[c]);
      e2[c*2 +: 2] = 2'(cnt2[c]);
    end
    chk("in_ready8",  32'(bus8.in_ready),  32'(m_in_ready()));
    chk("in_ready2",  32'(bus2.in_ready),  32'(m_in_ready()));
    chk("out_valid8", 32'(bus8.out_valid), 32'(m_out_valid()));
    chk("out_valid2", 32'(bus2.out_valid), 32'(m_out_valid()));
    chk("y8",         32'(bus8.y),         32'(last_y));
    chk("y2",         32'(bus2.y),         32'(last_y));
    chk("tog8",       bus8.tog_cnt,        e8);
    chk("tog2",       32'(bus2.tog_cnt),   32'(e2));
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] av,
                      input logic ordy, input logic clr);
    rn_t = r; iv_t = v; a_t = av; ordy_t = ordy; clr_t = clr;
    #1;
    if (checking) check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    // Reset held two cycles with a word offered
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    checking = 1;
    step(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    chk("rst_y",    32'(bus8.y),         32'hF);
    chk("rst_ov",   32'(bus8.out_valid), 32'h0);
    chk("rst_tog",  bus8.tog_cnt,        32'h0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("rst_rdy",  32'(bus8.in_ready),  32'h1);

    // Single word, two-edge latency
    step(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    chk("sw_ov_early", 32'(bus8.out_valid), 32'h0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("sw_ov",    32'(bus8.out_valid), 32'h1);
    chk("sw_y",     32'(bus8.y),         32'h0);
    chk("sw_tog",   bus8.tog_cnt,        32'h01010101);
    step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("sw2_y",    32'(bus8.y),         32'hE);
    chk("sw2_tog",  bus8.tog_cnt,        32'h02020201);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: only two words fit
    step(1'b1, 1'b1, 16'h000F, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0F00, 1'b0, 1'b0);
    chk("bp_rdy",   32'(bus8.in_ready),  32'h0);
    chk("bp_y0",    32'(bus8.y),         32'hE);
    step(1'b1, 1'b1, 16'h0F00, 1'b1, 1'b0);
    chk("bp_y1",    32'(bus8.y),         32'hD);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("bp_y2",    32'(bus8.y),         32'hB);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("bp_drain", 32'(bus8.out_valid), 32'h0);

    // Saturation of the 2-bit counters
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, (i % 2 == 0) ? 16'h0003 : 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("sat_c0",   32'(bus2.tog_cnt[1:0]), 32'h3);
    chk("sat8_c0",  32'(bus8.tog_cnt[7:0]), 32'h6);

    // Clear on the same edge as a toggling load
    step(1'b1, 1'b1, 16'h0003, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("clr_tog",  bus8.tog_cnt,        32'h0);
    chk("clr_y",    32'(bus8.y),         32'hE);

    // Reset with both stages full
    step(1'b1, 1'b1, 16'h00F0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h0F00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk("mrst_ov",  32'(bus8.out_valid), 32'h0);
    chk("mrst_y",   32'(bus8.y),         32'hF);
    step(1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("mrst_ov2", 32'(bus8.out_valid), 32'h1);
    chk("mrst_y2",  32'(bus8.y),         32'hE);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 3) != 0),
           16'($urandom),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
